execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 218 +++++++++++++++++++++
 tb/tb_execute_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Execute stage of a small in-order pipeline. It takes decoded operands from
//   the decode/execute register, forwards the previous result where it is
//   needed, and registers the ALU result, store data, destination index and
//   write enables into the execute/memory register. Multiplies run on a
//   32-cycle iterative shift-add engine, and the stage stalls upstream while
//   a multiply is running.
//
// Ports
//   clock              : sole clock, rising edge
//   reset              : synchronous, active-high
//   reg_rs1_d1/_rs2_d1 : source operand values (32b)
//   immediate_value_d1 : sign-extended immediate (32b)
//   opcode_d1          : operation code (6b)
//   rs1_d1/rs2_d1/rd_d1: source/destination register indices (5b)
//   register_we_d1     : register-file write enable
//   data_we_d1         : data-memory write enable
//   alu_result_d2      : registered result, or store address (32b)
//   store_data_d2      : registered store data (32b)
//   rd_d2              : registered destination index (5b)
//   register_we_d2     : registered register-file write enable
//   data_we_d2         : registered data-memory write enable
//   stall              : high while a multiply is in progress
//
// Multiply FSM
//   state  | meaning
//   S_IDLE | normal single-cycle execution; a MUL here starts the engine
//   S_BUSY | shift-add in progress, inputs ignored, stall asserted
// -----------------------------------------------------------------------------
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] reg_rs1_d1,
  input  logic [31:0] reg_rs2_d1,
  input  logic [31:0] immediate_value_d1,
  input  logic [5:0]  opcode_d1,
  input  logic [4:0]  rs1_d1,
  input  logic [4:0]  rs2_d1,
  input  logic [4:0]  rd_d1,
  input  logic        register_we_d1,
  input  logic        data_we_d1,
  output logic [31:0] alu_result_d2,
  output logic [31:0] store_data_d2,
  output logic [4:0]  rd_d2,
  output logic        register_we_d2,
  output logic        data_we_d2,
  output logic        stall
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_SLT  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b000110;
  localparam logic [5:0] OP_SLL  = 6'b000111;
  localparam logic [5:0] OP_SRL  = 6'b001000;
  localparam logic [5:0] OP_MUL  = 6'b001001;
  localparam logic [5:0] OP_SW   = 6'b001010;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] mul_a_q, mul_a_d;      // multiplicand, shifted left each cycle
  logic [31:0] mul_b_q, mul_b_d;      // multiplier, shifted right each cycle
  logic [31:0] mul_acc_q, mul_acc_d;  // low 32 bits of the partial product
  logic [4:0]  mul_rd_q, mul_rd_d;
  logic        mul_we_q, mul_we_d;

  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_data_q, store_data_d;
  logic [4:0]  rd_q, rd_d;
  logic        register_we_q, register_we_d;
  logic        data_we_q, data_we_d;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_val;
  logic        op_valid;
  logic        op_is_sw;
  logic [31:0] mul_sum;

  // Forward the previous result when it targets a non-zero source register.
  always_comb begin
    op_a = reg_rs1_d1;
    op_b = reg_rs2_d1;
    if (register_we_q && (rd_q != 5'd0) && (rd_q == rs1_d1)) op_a = alu_result_q;
    if (register_we_q && (rd_q != 5'd0) && (rd_q == rs2_d1)) op_b = alu_result_q;
  end

  always_comb begin
    alu_val  = 32'd0;
    op_valid = 1'b1;
    op_is_sw = 1'b0;
    case (opcode_d1)
      OP_ADD:  alu_val = op_a + op_b;
      OP_SUB:  alu_val = op_a - op_b;
      OP_AND:  alu_val = op_a & op_b;
      OP_OR:   alu_val = op_a | op_b;
      OP_XOR:  alu_val = op_a ^ op_b;
      OP_SLT:  alu_val = {31'd0, ($signed(op_a) < $signed(op_b))};
      OP_ADDI: alu_val = op_a + immediate_value_d1;
      OP_SLL:  alu_val = op_a << op_b[4:0];
      OP_SRL:  alu_val = op_a >> op_b[4:0];
      OP_SW: begin
        alu_val  = op_a + immediate_value_d1;
        op_is_sw = 1'b1;
      end
      default: op_valid = 1'b0;
    endcase
  end

  // One multiplier bit per cycle; only the low 32 bits of the product survive.
  assign mul_sum = mul_acc_q + (mul_b_q[0] ? mul_a_q : 32'd0);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_acc_d     = mul_acc_q;
    mul_rd_d      = mul_rd_q;
    mul_we_d      = mul_we_q;
    alu_result_d  = alu_result_q;
    store_data_d  = store_data_q;
    rd_d          = rd_q;
    register_we_d = register_we_q;
    data_we_d     = data_we_q;

    case (state_q)
      S_IDLE: begin
        if (opcode_d1 == OP_MUL) begin
          mul_a_d       = op_a;
          mul_b_d       = op_b;
          mul_acc_d     = 32'd0;
          mul_rd_d      = rd_d1;
          mul_we_d      = register_we_d1;
          count_d       = 5'd0;
          register_we_d = 1'b0;
          data_we_d     = 1'b0;
          state_d       = S_BUSY;
        end else if (op_valid) begin
          alu_result_d  = alu_val;
          store_data_d  = op_is_sw ? op_b : 32'd0;
          rd_d          = rd_d1;
          register_we_d = register_we_d1 && (rd_d1 != 5'd0);
          data_we_d     = data_we_d1;
        end else begin
          alu_result_d  = 32'd0;
          store_data_d  = 32'd0;
          rd_d          = rd_d1;
          register_we_d = 1'b0;
          data_we_d     = 1'b0;
        end
      end
      S_BUSY: begin
        mul_acc_d     = mul_sum;
        mul_a_d       = mul_a_q << 1;
        mul_b_d       = mul_b_q >> 1;
        count_d       = count_q + 5'd1;
        register_we_d = 1'b0;
        data_we_d     = 1'b0;
        if (count_q == 5'd31) begin
          alu_result_d  = mul_sum;
          store_data_d  = 32'd0;
          rd_d          = mul_rd_q;
          register_we_d = mul_we_q && (mul_rd_q != 5'd0);
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= 5'd0;
      mul_a_q       <= 32'd0;
      mul_b_q       <= 32'd0;
      mul_acc_q     <= 32'd0;
      mul_rd_q      <= 5'd0;
      mul_we_q      <= 1'b0;
      alu_result_q  <= 32'd0;
      store_data_q  <= 32'd0;
      rd_q          <= 5'd0;
      register_we_q <= 1'b0;
      data_we_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_acc_q     <= mul_acc_d;
      mul_rd_q      <= mul_rd_d;
      mul_we_q      <= mul_we_d;
      alu_result_q  <= alu_result_d;
      store_data_q  <= store_data_d;
      rd_q          <= rd_d;
      register_we_q <= register_we_d;
      data_we_q     <= data_we_d;
    end
  end

  assign stall          = (state_q == S_BUSY);
  assign alu_result_d2  = alu_result_q;
  assign store_data_d2  = store_data_q;
  assign rd_d2          = rd_q;
  assign register_we_d2 = register_we_q;
  assign data_we_d2     = data_we_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Directed vectors with hand-computed expectations. The driver pushes each
//   expected response, tagged with the clock cycle it should be visible in,
//   into a scoreboard queue; the monitor pops and compares on every falling
//   edge.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_SLT  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b000110;
  localparam logic [5:0] OP_SLL  = 6'b000111;
  localparam logic [5:0] OP_SRL  = 6'b001000;
  localparam logic [5:0] OP_MUL  = 6'b001001;
  localparam logic [5:0] OP_SW   = 6'b001010;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  // mask bits: [5] alu [4] store data [3] rd [2] reg we [1] data we [0] stall
  localparam logic [5:0] M_ALL = 6'b111111;
  localparam logic [5:0] M_R   = 6'b101111;
  localparam logic [5:0] M_NOP = 6'b110111;
  localparam logic [5:0] M_CTL = 6'b000111;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] reg_rs1_d1, reg_rs2_d1, immediate_value_d1;
  logic [5:0]  opcode_d1;
  logic [4:0]  rs1_d1, rs2_d1, rd_d1;
  logic        register_we_d1, data_we_d1;
  logic [31:0] alu_result_d2, store_data_d2;
  logic [4:0]  rd_d2;
  logic        register_we_d2, data_we_d2;
  logic        stall;

  execute_stage dut (
    .clock              (clock),
    .reset              (reset),
    .reg_rs1_d1         (reg_rs1_d1),
    .reg_rs2_d1         (reg_rs2_d1),
    .immediate_value_d1 (immediate_value_d1),
    .opcode_d1          (opcode_d1),
    .rs1_d1             (rs1_d1),
    .rs2_d1             (rs2_d1),
    .rd_d1              (rd_d1),
    .register_we_d1     (register_we_d1),
    .data_we_d1         (data_we_d1),
    .alu_result_d2      (alu_result_d2),
    .store_data_d2      (store_data_d2),
    .rd_d2              (rd_d2),
    .register_we_d2     (register_we_d2),
    .data_we_d2         (data_we_d2),
    .stall              (stall)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int          cyc;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rwe;
    logic        dwe;
    logic        stl;
    logic [5:0]  mask;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic expect_at(input int c, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input logic rwe, input logic dwe,
                           input logic stl, input logic [5:0] mask, input string nm);
    exp_t e;
    e.cyc = c; e.alu = alu; e.sd = sd; e.rd = rd; e.rwe = rwe; e.dwe = dwe;
    e.stl = stl; e.mask = mask; e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs1, input logic [31:0] a,
                       input logic [4:0] rs2, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rd, input logic rwe, input logic dwe);
    opcode_d1 = op; rs1_d1 = rs1; reg_rs1_d1 = a; rs2_d1 = rs2; reg_rs2_d1 = b;
    immediate_value_d1 = imm; rd_d1 = rd; register_we_d1 = rwe; data_we_d1 = dwe;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rs1, input logic [31:0] a,
                       input logic [4:0] rs2, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rd, input logic rwe, input logic dwe,
                       input logic [31:0] x_alu, input logic [31:0] x_sd, input logic x_rwe,
                       input logic x_dwe, input logic [5:0] mask, input string nm);
    drive(op, rs1, a, rs2, b, imm, rd, rwe, dwe);
    expect_at(cyc + 1, x_alu, x_sd, rd, x_rwe, x_dwe, 1'b0, mask, nm);
    @(negedge clock);
  endtask

  // Called one cycle after a MUL was accepted: 31 more stalled cycles, then the result.
  task automatic mul_window(input logic [4:0] rd, input logic [31:0] prod,
                            input logic rwe, input string nm);
    for (int k = 1; k <= 31; k++)
      expect_at(cyc + k, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, M_CTL, {nm, "_busy"});
    expect_at(cyc + 32, prod, 32'd0, rd, rwe, 1'b0, 1'b0, M_R, nm);
  endtask

  exp_t mon_e;
  logic mon_ok;
  always @(negedge clock) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if (mon_e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: check slot missed, due cycle %0d, now %0d", mon_e.nm, mon_e.cyc, cyc);
      end else begin
        mon_ok = 1'b1;
        if (mon_e.mask[5] && alu_result_d2  !== mon_e.alu) mon_ok = 1'b0;
        if (mon_e.mask[4] && store_data_d2  !== mon_e.sd)  mon_ok = 1'b0;
        if (mon_e.mask[3] && rd_d2          !== mon_e.rd)  mon_ok = 1'b0;
        if (mon_e.mask[2] && register_we_d2 !== mon_e.rwe) mon_ok = 1'b0;
        if (mon_e.mask[1] && data_we_d2     !== mon_e.dwe) mon_ok = 1'b0;
        if (mon_e.mask[0] && stall          !== mon_e.stl) mon_ok = 1'b0;
        if (!mon_ok) begin
          n_bad++;
          $display("FAIL %s @cyc %0d (mask %b): got alu=%h sd=%h rd=%0d rwe=%b dwe=%b stall=%b, want alu=%h sd=%h rd=%0d rwe=%b dwe=%b stall=%b",
                   mon_e.nm, cyc, mon_e.mask, alu_result_d2, store_data_d2, rd_d2,
                   register_we_d2, data_we_d2, stall, mon_e.alu, mon_e.sd, mon_e.rd,
                   mon_e.rwe, mon_e.dwe, mon_e.stl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(OP_ADD, 5'd1, 32'd9, 5'd2, 32'd9, 32'd0, 5'd1, 1'b1, 1'b1);
    @(negedge clock);
    expect_at(cyc + 1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, M_ALL, "reset_state");
    @(negedge clock);
    reset = 1'b0;

    issue(OP_ADD,  5'd1,  32'd5,         5'd2,  32'd7,         32'd0, 5'd3,  1, 0, 32'd12,        32'd0, 1, 0, M_R, "add_5_7");
    issue(OP_SUB,  5'd3,  32'd0,         5'd4,  32'd2,         32'd0, 5'd5,  1, 0, 32'd10,        32'd0, 1, 0, M_R, "sub_fwd_a");
    issue(OP_AND,  5'd6,  32'hF0F0_1234, 5'd7,  32'h0FF0_FF00, 32'd0, 5'd6,  1, 0, 32'h00F0_1200, 32'd0, 1, 0, M_R, "and");
    issue(OP_OR,   5'd8,  32'hF0F0_1234, 5'd9,  32'h0FF0_FF00, 32'd0, 5'd7,  1, 0, 32'hFFF0_FF34, 32'd0, 1, 0, M_R, "or");
    issue(OP_XOR,  5'd10, 32'hAAAA_5555, 5'd11, 32'hFFFF_0000, 32'd0, 5'd12, 1, 0, 32'h5555_5555, 32'd0, 1, 0, M_R, "xor");
    issue(OP_SLT,  5'd13, 32'hFFFF_FFFF, 5'd14, 32'd1,         32'd0, 5'd15, 1, 0, 32'd1,         32'd0, 1, 0, M_R, "slt_m1_1");
    issue(OP_SLT,  5'd16, 32'd1,         5'd17, 32'hFFFF_FFFF, 32'd0, 5'd18, 1, 0, 32'd0,         32'd0, 1, 0, M_R, "slt_1_m1");
    issue(OP_ADDI, 5'd19, 32'd100,       5'd0,  32'd0, 32'hFFFF_FFFC, 5'd20, 1, 0, 32'd96,        32'd0, 1, 0, M_R, "addi_neg");
    issue(OP_SLL,  5'd21, 32'd3,         5'd22, 32'd34,        32'd0, 5'd23, 1, 0, 32'd12,        32'd0, 1, 0, M_R, "sll_34");
    issue(OP_SRL,  5'd24, 32'h8000_0000, 5'd25, 32'd35,        32'd0, 5'd26, 1, 0, 32'h1000_0000, 32'd0, 1, 0, M_R, "srl_35");
    issue(OP_SW,   5'd27, 32'h100,       5'd28, 32'hAB, 32'hFFFF_FFFC, 5'd0, 0, 1, 32'hFC,        32'hAB, 0, 1, M_ALL, "sw");
    issue(OP_ADD,  5'd29, 32'd1,         5'd30, 32'd1,         32'd0, 5'd0,  1, 0, 32'd2,         32'd0, 0, 0, M_R, "add_rd0");
    issue(OP_NOP,  5'd1,  32'd7,         5'd2,  32'd7,         32'd9, 5'd4,  1, 1, 32'd0,         32'd0, 0, 0, M_NOP, "nop");
    issue(OP_ADD,  5'd1,  32'd10,        5'd2,  32'd20,        32'd0, 5'd9,  1, 0, 32'd30,        32'd0, 1, 0, M_R, "add_10_20");
    issue(OP_SUB,  5'd31, 32'd100,       5'd9,  32'd0,         32'd0, 5'd10, 1, 0, 32'd70,        32'd0, 1, 0, M_R, "sub_fwd_b");
    issue(OP_ADD,  5'd1,  32'd5,         5'd2,  32'd5,         32'd0, 5'd11, 0, 0, 32'd10,        32'd0, 0, 0, M_R, "add_no_we");
    issue(OP_ADD,  5'd11, 32'd1,         5'd3,  32'd1,         32'd0, 5'd12, 1, 0, 32'd2,         32'd0, 1, 0, M_R, "no_fwd_we0");
    issue(OP_ADD,  5'd1,  32'hFFFF_FFFF, 5'd2,  32'd2,         32'd0, 5'd13, 1, 0, 32'd1,         32'd0, 1, 0, M_R, "add_wrap");

    // MUL 1000*3000 with a dependent ADD held behind it
    drive(OP_MUL, 5'd1, 32'd1000, 5'd2, 32'd3000, 32'd0, 5'd4, 1'b1, 1'b0);
    expect_at(cyc + 1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, M_CTL, "mul_accept");
    @(negedge clock);
    drive(OP_ADD, 5'd4, 32'd0, 5'd5, 32'd1, 32'd0, 5'd6, 1'b1, 1'b0);
    mul_window(5'd4, 32'd3000000, 1'b1, "mul_1000x3000");
    expect_at(cyc + 33, 32'd3000001, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, M_R, "fwd_from_mul");
    repeat (33) @(negedge clock);

    // Back-to-back MULs; the second forwards A from the first (42*2)
    drive(OP_MUL, 5'd10, 32'd7, 5'd11, 32'd6, 32'd0, 5'd7, 1'b1, 1'b0);
    expect_at(cyc + 1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, M_CTL, "mul2_accept");
    @(negedge clock);
    drive(OP_MUL, 5'd7, 32'd0, 5'd3, 32'd2, 32'd0, 5'd8, 1'b1, 1'b0);
    mul_window(5'd7, 32'd42, 1'b1, "mul_7x6");
    expect_at(cyc + 33, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, M_CTL, "mul3_accept");
    repeat (33) @(negedge clock);
    drive(OP_NOP, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    mul_window(5'd8, 32'd84, 1'b1, "mul_fwd_42x2");
    expect_at(cyc + 33, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, M_NOP, "nop_after_mul");
    repeat (33) @(negedge clock);

    // All-ones squared: low 32 bits of the product are 1
    drive(OP_MUL, 5'd20, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFF, 32'd0, 5'd14, 1'b1, 1'b0);
    expect_at(cyc + 1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, M_CTL, "mul4_accept");
    @(negedge clock);
    drive(OP_NOP, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    mul_window(5'd14, 32'd1, 1'b1, "mul_ones");
    repeat (33) @(negedge clock);

    // Reset in the middle of a multiply
    drive(OP_MUL, 5'd12, 32'd5, 5'd13, 32'd5, 32'd0, 5'd9, 1'b1, 1'b0);
    expect_at(cyc + 1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, M_CTL, "mul5_accept");
    @(negedge clock);
    drive(OP_NOP, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++)
      expect_at(cyc + k, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, M_CTL, "mul5_busy");
    repeat (8) @(negedge clock);
    reset = 1'b1;
    expect_at(cyc + 1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, M_ALL, "reset_mid_mul");
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 40; k++)
      expect_at(cyc + k, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, M_NOP, "no_write_after_abort");
    repeat (40) @(negedge clock);
    issue(OP_ADD, 5'd1, 32'd2, 5'd2, 32'd2, 32'd0, 5'd1, 1, 0, 32'd4, 32'd0, 1, 0, M_R, "add_after_abort");

    repeat (3) @(negedge clock);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
